// File: rtl/phase_sequencer_if.sv
// Control bundle between the instruction-phase sequencer and the datapath that consumes
// its phase enables. The sequencer attaches through the slave modport; the processor-side
// controller (or a bench) attaches through the master modport.
interface phase_sequencer_if #(
    parameter int unsigned N_PHASES = 5,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned IDX_W = $clog2(N_PHASES);

    logic                run;
    logic                stall;
    logic                halt_req;
    logic                step_mode;
    logic                step;
    logic [N_PHASES-1:0] phase;
    logic [IDX_W-1:0]    phase_idx;
    logic                last_phase;
    logic                halted;
    logic                paused;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        output run, stall, halt_req, step_mode, step,
        input  phase, phase_idx, last_phase, halted, paused, instr_count
    );

    modport slave (
        input  run, stall, halt_req, step_mode, step,
        output phase, phase_idx, last_phase, halted, paused, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: one-hot phase generator with stall, halt/restart,
// a retired-instruction counter and optional single-step debug.
// Optional feature: define PHASE_SEQ_STEP_EN to enable single-step pausing after each retire.
// Without it, step_mode/step are ignored and paused is tied low.
module phase_sequencer #(
    parameter int unsigned N_PHASES = 5,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    phase_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_PHASES);

    typedef enum logic [1:0] {StRun, StHalt, StPause} state_e;

    state_e              state_q, state_d;
    logic [N_PHASES-1:0] phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                step_pause;
    logic                resume;

`ifdef PHASE_SEQ_STEP_EN
    assign step_pause = bus.step_mode;
    assign resume     = bus.step | bus.run;
`else
    logic unused_step;
    assign unused_step = bus.step_mode ^ bus.step;
    assign step_pause  = 1'b0;
    assign resume      = bus.run;
`endif

    // State, phase and counter registers; synchronous active-low reset restarts at phase 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            phase_q <= N_PHASES'(1);
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: advance, retire, halt or pause; HALT/PAUSE park phase at all-zero.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (!bus.stall) begin
                    if (phase_q[N_PHASES-1]) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        idx_d = '0;
                        if (bus.halt_req) begin
                            state_d = StHalt;
                            phase_d = '0;
                        end else if (step_pause) begin
                            state_d = StPause;
                            phase_d = '0;
                        end else begin
                            phase_d = N_PHASES'(1);
                        end
                    end else begin
                        phase_d = {phase_q[N_PHASES-2:0], 1'b0};
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            StHalt: begin
                if (bus.run) begin
                    state_d = StRun;
                    phase_d = N_PHASES'(1);
                    idx_d   = '0;
                end
            end
            StPause: begin
                if (resume) begin
                    state_d = StRun;
                    phase_d = N_PHASES'(1);
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StRun;
                phase_d = N_PHASES'(1);
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are pure decodes of the registers above.
    always_comb begin
        bus.phase       = phase_q;
        bus.phase_idx   = idx_q;
        bus.last_phase  = phase_q[N_PHASES-1] & (state_q == StRun);
        bus.halted      = (state_q == StHalt);
`ifdef PHASE_SEQ_STEP_EN
        bus.paused      = (state_q == StPause);
`else
        bus.paused      = 1'b0;
`endif
        bus.instr_count = cnt_q;
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer: a 5-phase/16-bit instance for the main
// behaviour and a 2-phase/4-bit instance for counter wrap.
module tb_phase_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    phase_sequencer_if #(.N_PHASES(5), .CNT_W(16)) sb ();
    phase_sequencer_if #(.N_PHASES(2), .CNT_W(4))  sb_s ();

    phase_sequencer #(.N_PHASES(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sb.slave)
    );

    phase_sequencer #(.N_PHASES(2), .CNT_W(4)) u_dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (sb_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b0;
        rst_s        = 1'b0;
        sb.run       = 1'b0;
        sb.stall     = 1'b0;
        sb.halt_req  = 1'b0;
        sb.step_mode = 1'b0;
        sb.step      = 1'b0;
        sb_s.run       = 1'b0;
        sb_s.stall     = 1'b0;
        sb_s.halt_req  = 1'b0;
        sb_s.step_mode = 1'b0;
        sb_s.step      = 1'b0;

        // Reset state
        tick();
        check("rst_phase", sb.phase, 32'h1);
        check("rst_idx", sb.phase_idx, 0);
        check("rst_halted", sb.halted, 0);
        check("rst_paused", sb.paused, 0);
        check("rst_count", sb.instr_count, 0);
        check("rst_last", sb.last_phase, 0);

        // Free run: 1,2,4,8,16 repeating
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("run_phase", sb.phase, 32'h1 << (i % 5));
            check("run_idx", sb.phase_idx, i % 5);
            check("run_last", sb.last_phase, (i % 5) == 4);
            tick();
        end
        check("run_count3", sb.instr_count, 3);
        check("run_wrap_phase", sb.phase, 32'h1);

        // Stall holds phase 4 for four cycles total
        tick(2);
        check("stall_enter", sb.phase, 32'h4);
        sb.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", sb.phase, 32'h4);
            check("stall_idx", sb.phase_idx, 2);
        end
        sb.stall = 1'b0;
        tick();
        check("stall_release", sb.phase, 32'h8);
        check("stall_count", sb.instr_count, 3);
        tick(2);
        check("stall_retire", sb.instr_count, 4);

        // halt_req with stall in last phase: stall wins; run in RUN ignored
        tick(4);
        check("pre_halt_last", sb.last_phase, 1);
        sb.halt_req = 1'b1;
        sb.stall    = 1'b1;
        sb.run      = 1'b1;
        tick();
        check("halt_stalled_phase", sb.phase, 32'h10);
        check("halt_stalled_halted", sb.halted, 0);
        check("halt_stalled_count", sb.instr_count, 4);
        sb.stall = 1'b0;
        sb.run   = 1'b0;
        tick();
        check("halt_halted", sb.halted, 1);
        check("halt_phase", sb.phase, 0);
        check("halt_idx", sb.phase_idx, 0);
        check("halt_last", sb.last_phase, 0);
        check("halt_count", sb.instr_count, 5);

        // HALT ignores stall, halt_req and step for 10 cycles
        sb.stall = 1'b1;
        sb.step  = 1'b1;
        tick(10);
        check("halt_hold", sb.halted, 1);
        check("halt_hold_phase", sb.phase, 0);
        sb.stall    = 1'b0;
        sb.step     = 1'b0;
        sb.halt_req = 1'b0;
        sb.run      = 1'b1;
        tick();
        sb.run = 1'b0;
        check("restart_phase", sb.phase, 32'h1);
        check("restart_halted", sb.halted, 0);
        check("restart_count", sb.instr_count, 5);

        // Reset mid-instruction, with stall also asserted
        tick(13);
        check("mid_phase", sb.phase, 32'h8);
        check("mid_count", sb.instr_count, 7);
        rst      = 1'b0;
        sb.stall = 1'b1;
        tick();
        rst      = 1'b1;
        sb.stall = 1'b0;
        check("mid_rst_phase", sb.phase, 32'h1);
        check("mid_rst_count", sb.instr_count, 0);
        check("mid_rst_halted", sb.halted, 0);

        // Reset from HALT
        tick(4);
        sb.halt_req = 1'b1;
        tick();
        sb.halt_req = 1'b0;
        check("halt2_halted", sb.halted, 1);
        check("halt2_count", sb.instr_count, 1);
        rst    = 1'b0;
        sb.run = 1'b1;
        tick();
        rst    = 1'b1;
        sb.run = 1'b0;
        check("halt_rst_halted", sb.halted, 0);
        check("halt_rst_phase", sb.phase, 32'h1);
        check("halt_rst_count", sb.instr_count, 0);

`ifdef PHASE_SEQ_STEP_EN
        // Single-step: pause after each retire
        sb.step_mode = 1'b1;
        tick(5);
        check("step_paused", sb.paused, 1);
        check("step_phase0", sb.phase, 0);
        check("step_count1", sb.instr_count, 1);
        tick(3);
        check("step_idle", sb.paused, 1);
        sb.step = 1'b1;
        tick();
        sb.step = 1'b0;
        check("step_go_phase", sb.phase, 32'h1);
        check("step_go_paused", sb.paused, 0);
        tick(4);
        check("step_last", sb.phase, 32'h10);
        tick();
        check("step_repause", sb.paused, 1);
        check("step_count2", sb.instr_count, 2);
        sb.step = 1'b1;
        tick();
        sb.step = 1'b0;
        tick(4);
        sb.halt_req = 1'b1;
        tick();
        sb.halt_req = 1'b0;
        check("step_halt_halted", sb.halted, 1);
        check("step_halt_paused", sb.paused, 0);
        check("step_halt_count", sb.instr_count, 3);
        sb.run = 1'b1;
        tick();
        sb.run = 1'b0;
        check("step_restart", sb.phase, 32'h1);
        sb.step_mode = 1'b0;
`else
        // Feature disabled: step_mode/step have no effect
        sb.step_mode = 1'b1;
        sb.step      = 1'b1;
        tick(5);
        check("nostep_paused", sb.paused, 0);
        check("nostep_phase", sb.phase, 32'h1);
        check("nostep_count", sb.instr_count, 1);
        sb.step_mode = 1'b0;
        sb.step      = 1'b0;
`endif

        // Small build: 2 phases, 4-bit counter wraps 15 -> 0
        rst_s = 1'b1;
        tick();
        check("s_phase2", sb_s.phase, 32'h2);
        check("s_idx1", sb_s.phase_idx, 1);
        check("s_last", sb_s.last_phase, 1);
        tick();
        check("s_count1", sb_s.instr_count, 1);
        tick(28);
        check("s_count15", sb_s.instr_count, 15);
        tick(2);
        check("s_wrap", sb_s.instr_count, 0);
        check("s_wrap_phase", sb_s.phase, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-cycle control sequencer: the successor to the fixed five-phase counter and halt flip-flop in the processor top level. Generates a one-hot phase vector of configurable length that drives per-phase load enables (IR, register file, flags, PC) and supports memory stalls, halt with external restart, and an optional single-step debug mode. Also keeps a retired-instruction counter for bring-up and performance checks.

## Interface
- N_PHASES, 5, number of phases per instruction; legal range 2..16
- CNT_W, 16, width of retired-instruction counter
- IDX_W, $clog2(N_PHASES), local, width of phase_idx; not overridable
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- run  in  1  restart request; honoured only in HALT or PAUSE
- stall  in  1  hold current phase (e.g. memory wait); honoured only in RUN
- halt_req  in  1  decoded HLT; sampled only in last phase of an unstalled cycle
- step_mode  in  1  single-step enable (see Configuration)
- step  in  1  advance one instruction from PAUSE (see Configuration)
- phase  out  N_PHASES  one-hot phase; all-zero outside RUN
- phase_idx  out  IDX_W  binary index of active phase; 0 outside RUN
- last_phase  out  1  phase[N_PHASES-1] & RUN
- halted  out  1  1 in HALT
- paused  out  1  1 in PAUSE
- instr_count  out  CNT_W  retired-instruction count

## Operation
- States: RUN, HALT, PAUSE. All outputs registered, derived from state/phase registers only.
- Reset (rst=0 at edge): RUN, phase=1 (bit 0), phase_idx=0, halted=0, paused=0, instr_count=0. Applies from any state, mid-instruction included; next instruction starts at phase 0.
- RUN, stall=1: phase, phase_idx, count held; halt_req ignored.
- RUN, stall=0, not last phase: phase shifts left one bit, phase_idx+1.
- RUN, stall=0, last phase ("retire"): instr_count+1 (wraps modulo 2^CNT_W), then:
  - halt_req=1 -> HALT (halt wins over step pause);
  - else step pause condition true -> PAUSE;
  - else phase wraps to bit 0, phase_idx=0, stay RUN.
- HALT: phase=0, halted=1. run=1 -> RUN at phase 0. stall, halt_req, step ignored.
- PAUSE: phase=0, paused=1. step=1 or run=1 -> RUN at phase 0; run additionally clears nothing (step_mode still governs next retire).
- run/step in RUN are ignored; no request is latched for later.
- phase is always one-hot in RUN and zero otherwise; no other encodings reachable.

## Timing
- One phase per unstalled cycle; instruction latency N_PHASES cycles plus stall cycles.
- Retire edge: new instr_count visible in same cycle as phase[0] (or halted/paused).
- halt_req at retire edge t: halted=1 from cycle t+1; phase=0 from t+1.
- run asserted in cycle t while halted: phase[0]=1 and halted=0 at t+1. Minimum halt duration 1 cycle.
- stall and halt_req both 1 in last phase: stall wins, halt_req resampled on the first unstalled last-phase cycle.
- rst has priority over every other input in the same cycle.

## Configuration
- PHASE_SEQ_STEP_EN defined: step pause condition = step_mode; PAUSE reachable; step/run leave it.
- Not defined: step_mode and step ports present but ignored; PAUSE unreachable; paused constant 0.

## Test plan
- Reset then free run, N_PHASES=5, stall=0: phase sequence 1,2,4,8,16,1,...; instr_count=3 after 15 cycles; phase_idx tracks 0..4.
- stall=1 for 3 cycles while phase=4: phase holds 4 for 4 cycles total, then 8; instr_count unchanged until retire.
- halt_req=1 in phase 16: next cycle halted=1, phase=0, count incremented; run=1 after 10 cycles -> phase=1 next cycle, halted=0.
- halt_req=1 with stall=1 in last phase, then stall=0: halt only after stall drops; run during RUN has no effect.
- rst=0 mid-instruction (phase=8, count=7): next cycle phase=1, count=0, halted=0; also from HALT.
- With PHASE_SEQ_STEP_EN, step_mode=1: after each retire paused=1, phase=0; step pulse -> one full 5-phase instruction then PAUSE again; halt_req at retire -> HALT, paused=0. N_PHASES=2 and CNT_W=4 build: count wraps 15->0.
